// File: rtl/cvp14_pkg.sv
// cvp14_pkg: shared widths, op encoding and state enum
// for the CVP14 vector load/store path.
package cvp14_pkg;
  localparam int VLEN = 16;
  localparam int DW   = 16;
  localparam int AW   = 16;

  localparam logic OP_LOAD  = 1'b0;
  localparam logic OP_STORE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LDRAIN,
    ST_STORE,
    ST_DONE
  } vldst_state_e;
endpackage

// File: rtl/vldst_rdpipe.sv
// vldst_rdpipe: DEPTH-deep {valid, index} shift register
// tracking outstanding DRAM reads until their data lands.
module vldst_rdpipe #(
  parameter int DEPTH = 1,
  parameter int IW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_valid,
  input  logic [IW-1:0] i_idx,
  output logic          o_valid,
  output logic [IW-1:0] o_idx,
  output logic          o_pre_valid,
  output logic          o_pending
);
  import cvp14_pkg::*;

  logic [DEPTH-1:0] r_v;
  logic [IW-1:0]    r_idx [DEPTH];
  logic [DEPTH-1:0] w_v_in;
  logic [IW-1:0]    w_idx_in [DEPTH];

  always_comb begin
    w_v_in[0]   = i_valid;
    w_idx_in[0] = i_idx;
    for (int j = 1; j < DEPTH; j++) begin
      w_v_in[j]   = r_v[j-1];
      w_idx_in[j] = r_idx[j-1];
    end
  end

  // pending = a read still upstream of the final stage
  always_comb begin
    o_pending = 1'b0;
    for (int j = 0; j < DEPTH-1; j++)
      o_pending = o_pending | r_v[j];
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_v <= '0;
      for (int j = 0; j < DEPTH; j++)
        r_idx[j] <= '0;
    end else begin
      r_v <= w_v_in;
      for (int j = 0; j < DEPTH; j++)
        r_idx[j] <= w_idx_in[j];
    end
  end

  assign o_valid     = r_v[DEPTH-1];
  assign o_idx       = r_idx[DEPTH-1];
  assign o_pre_valid = w_v_in[DEPTH-1];
endmodule

// File: rtl/vldst_unit.sv
// vldst_unit: streams one vector register between the VRF
// and DRAM, one element per cycle, on a single Start pulse.
module vldst_unit #(
  parameter int VLEN   = cvp14_pkg::VLEN,
  parameter int RD_LAT = 1
) (
  input  logic                     Clk1,
  input  logic                     Reset,
  input  logic                     Start,
  input  logic                     Op,
  input  logic [cvp14_pkg::AW-1:0] BaseAddr,
  output logic                     Busy,
  output logic                     Done,
  output logic [$clog2(VLEN)-1:0]  VrfIdx,
  input  logic [cvp14_pkg::DW-1:0] VrfRdData,
  output logic                     VrfWrEn,
  output logic [cvp14_pkg::DW-1:0] VrfWrData,
  output logic [cvp14_pkg::AW-1:0] Addr,
  output logic                     RD,
  output logic                     WR,
  output logic [cvp14_pkg::DW-1:0] DataOut,
  input  logic [cvp14_pkg::DW-1:0] DataIn
);
  import cvp14_pkg::*;

  localparam int IW = $clog2(VLEN);
  localparam logic [IW-1:0] LAST = IW'(VLEN-1);

  vldst_state_e  r_state;
  logic [IW-1:0] r_cnt;
  logic [AW-1:0] r_addr;
  logic          r_rd;
  logic          r_wr;
  logic          r_busy;
  logic          r_done;
  logic [DW-1:0] r_wdata;

  logic          w_pvalid;
  logic [IW-1:0] w_pidx;
  logic          w_pre;
  logic          w_pend;

  vldst_rdpipe #(
    .DEPTH(RD_LAT),
    .IW   (IW)
  ) u_rdpipe (
    .i_clk      (Clk1),
    .i_rst      (Reset),
    .i_valid    (r_rd),
    .i_idx      (r_cnt),
    .o_valid    (w_pvalid),
    .o_idx      (w_pidx),
    .o_pre_valid(w_pre),
    .o_pending  (w_pend)
  );

  always_ff @(posedge Clk1) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_addr  <= '0;
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_wdata <= '0;
    end else begin
      r_done <= 1'b0;
      // DataIn is valid at the RD_LAT-th edge after issue
      if (w_pre)
        r_wdata <= DataIn;
      unique case (r_state)
        ST_IDLE: begin
          if (Start) begin
            r_cnt  <= '0;
            r_addr <= BaseAddr;
            r_busy <= 1'b1;
            if (Op == OP_STORE) begin
              r_state <= ST_STORE;
              r_wr    <= 1'b1;
            end else begin
              r_state <= ST_LOAD;
              r_rd    <= 1'b1;
            end
          end
        end
        ST_LOAD: begin
          if (r_cnt == LAST) begin
            r_state <= ST_LDRAIN;
            r_rd    <= 1'b0;
            r_addr  <= '0;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_addr <= r_addr + 1'b1;
          end
        end
        ST_LDRAIN: begin
          if (!w_pend) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        ST_STORE: begin
          if (r_cnt == LAST) begin
            r_state <= ST_DONE;
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_cnt  <= r_cnt + 1'b1;
            r_addr <= r_addr + 1'b1;
          end
        end
        ST_DONE: r_state <= ST_IDLE;
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign Busy      = r_busy;
  assign Done      = r_done;
  assign RD        = r_rd;
  assign WR        = r_wr;
  assign Addr      = r_addr;
  assign VrfWrEn   = w_pvalid;
  assign VrfWrData = r_wdata;
  assign VrfIdx    = (r_state == ST_STORE) ? r_cnt : w_pidx;
  assign DataOut   = (r_state == ST_STORE) ? VrfRdData : '0;
endmodule

// File: tb/tb_vldst_unit.sv
// tb_vldst_unit: two DUTs (RD_LAT 1 and 3) against a
// cycle-timeline model plus directed literal checks.
module tb_vldst_unit;
  localparam int V = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst   [2];
  logic        start [2];
  logic        op    [2];
  logic [15:0] base  [2];
  logic        busy  [2];
  logic        done  [2];
  logic        wren  [2];
  logic        rd    [2];
  logic        wr    [2];
  logic [3:0]  vidx  [2];
  logic [15:0] vrd   [2];
  logic [15:0] wdata [2];
  logic [15:0] addr  [2];
  logic [15:0] dout  [2];
  logic [15:0] din   [2];

  logic [15:0] mem [2][65536];
  logic [15:0] vrf [2][V];

  int   n_cmp = 0;
  int   n_bad = 0;
  logic chk_en = 1'b0;

  function automatic int lat(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  task automatic chk(input string nm, input int d,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_cmp++;
    if (a !== e) begin
      n_bad++;
      $display("FAIL %s[%0d] t=%0t: got %h want %h",
               nm, d, $time, a, e);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_u
    localparam int L = (g == 0) ? 1 : 3;

    vldst_unit #(.VLEN(V), .RD_LAT(L)) u_dut (
      .Clk1     (clk),
      .Reset    (rst[g]),
      .Start    (start[g]),
      .Op       (op[g]),
      .BaseAddr (base[g]),
      .Busy     (busy[g]),
      .Done     (done[g]),
      .VrfIdx   (vidx[g]),
      .VrfRdData(vrd[g]),
      .VrfWrEn  (wren[g]),
      .VrfWrData(wdata[g]),
      .Addr     (addr[g]),
      .RD       (rd[g]),
      .WR       (wr[g]),
      .DataOut  (dout[g]),
      .DataIn   (din[g])
    );

    assign vrd[g] = vrf[g][vidx[g]];

    always @(posedge clk) begin
      if (wr[g]) mem[g][addr[g]] = dout[g];
      if (wren[g]) vrf[g][vidx[g]] = wdata[g];
    end

    if (L == 1) begin : g_l1
      assign din[g] = rd[g] ? mem[g][addr[g]] : 16'h0;
    end else begin : g_ln
      logic [15:0] dl [L-1];
      always @(posedge clk) begin
        dl[0] <= rd[g] ? mem[g][addr[g]] : 16'h0;
        for (int k = 1; k < L-1; k++)
          dl[k] <= dl[k-1];
      end
      assign din[g] = dl[L-2];
    end
  end

  // model: per-transfer cycle index t (t=1 is first busy cycle)
  logic        m_act  [2] = '{1'b0, 1'b0};
  logic        m_op   [2];
  int          m_t    [2];
  logic [15:0] m_base [2];

  function automatic int m_end(input int d);
    return m_op[d] ? V + 1 : V + lat(d) + 1;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst[d]) begin
        m_act[d] = 1'b0;
      end else if (m_act[d]) begin
        if (m_t[d] == m_end(d)) m_act[d] = 1'b0;
        else m_t[d]++;
      end else if (start[d]) begin
        m_act[d]  = 1'b1;
        m_t[d]    = 1;
        m_op[d]   = op[d];
        m_base[d] = base[d];
      end
    end
  end

  logic        e_rd, e_wr, e_busy, e_done, e_wren;
  logic [15:0] e_addr, e_dout, e_wd;
  int          e_idx, t, l;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        e_rd = 0; e_wr = 0; e_busy = 0;
        e_done = 0; e_wren = 0;
        e_addr = 0; e_dout = 0; e_wd = 0;
        e_idx = 0;
        t = m_t[d];
        l = lat(d);
        if (m_act[d] && !m_op[d]) begin
          e_rd = (t <= V);
          if (e_rd) e_addr = m_base[d] + 16'(t-1);
          e_wren = (t >= 1+l) && (t <= V+l);
          if (e_wren) begin
            e_idx = t - 1 - l;
            e_wd = mem[d][m_base[d] + 16'(e_idx)];
          end
          e_busy = (t <= V+l);
          e_done = (t == V+l+1);
        end else if (m_act[d]) begin
          e_wr = (t <= V);
          if (e_wr) begin
            e_addr = m_base[d] + 16'(t-1);
            e_idx = t - 1;
            e_dout = vrf[d][e_idx];
          end
          e_busy = (t <= V);
          e_done = (t == V+1);
        end
        chk("busy", d, 32'(busy[d]), 32'(e_busy));
        chk("done", d, 32'(done[d]), 32'(e_done));
        chk("rd", d, 32'(rd[d]), 32'(e_rd));
        chk("wr", d, 32'(wr[d]), 32'(e_wr));
        chk("wren", d, 32'(wren[d]), 32'(e_wren));
        chk("addr", d, 32'(addr[d]), 32'(e_addr));
        chk("dout", d, 32'(dout[d]), 32'(e_dout));
        if (e_wren || e_wr)
          chk("vidx", d, 32'(vidx[d]), 32'(e_idx));
        if (e_wren)
          chk("wdata", d, 32'(wdata[d]), 32'(e_wd));
      end
    end
  end

  // caller sits at posedge+1; returns at posedge+1
  task automatic run(input int d, input logic o,
                     input logic [15:0] b,
                     input int pulse_at,
                     input logic [15:0] pb,
                     input int rst_at,
                     output int dc, output int nr,
                     output int nw, output int nd);
    dc = -1; nr = 0; nw = 0; nd = 0;
    start[d] = 1'b1;
    op[d] = o;
    base[d] = b;
    @(posedge clk); #1;
    start[d] = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      if (c == pulse_at) begin
        start[d] = 1'b1;
        op[d] = ~o;
        base[d] = pb;
      end else begin
        start[d] = 1'b0;
      end
      rst[d] = (c == rst_at);
      @(negedge clk);
      if (done[d]) begin
        nd++;
        if (dc < 0) dc = c;
      end
      nr += int'(rd[d]);
      nw += int'(wr[d]);
      @(posedge clk); #1;
    end
    start[d] = 1'b0;
    rst[d] = 1'b0;
  endtask

  int dc, nr, nw, nd;

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1;
      start[d] = 1'b0;
      op[d] = 1'b0;
      base[d] = 16'h0;
    end
    for (int a = 0; a < 65536; a++) begin
      mem[0][a] = 16'(a) ^ 16'h3C3C;
      mem[1][a] = 16'(a) ^ 16'h3C3C;
    end
    for (int i = 0; i < V; i++) begin
      mem[0][16'h0100 + 16'(i)] = 16'hA000 + 16'(i);
      mem[1][16'h0100 + 16'(i)] = 16'hC000 + 16'(i);
      mem[0][16'hFFF8 + 16'(i)] = 16'hB000 + 16'(i);
      vrf[0][i] = 16'h0;
      vrf[1][i] = 16'h0;
    end
    @(posedge clk); #1;
    chk_en = 1'b1;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk("rst_vidx", d, 32'(vidx[d]), 32'h0);
      chk("rst_wdata", d, 32'(wdata[d]), 32'h0);
      chk("rst_addr", d, 32'(addr[d]), 32'h0);
    end
    @(posedge clk); #1;
    rst[0] = 1'b0;
    rst[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // load 0x0100, RD_LAT=1
    run(0, 1'b0, 16'h0100, 0, 16'h0, 0, dc, nr, nw, nd);
    chk("ld_done_cyc", 0, 32'(dc), 32'd18);
    chk("ld_nrd", 0, 32'(nr), 32'd16);
    chk("ld_nwr", 0, 32'(nw), 32'd0);
    chk("ld_ndone", 0, 32'(nd), 32'd1);
    for (int i = 0; i < V; i++)
      chk("ld_vrf", i, 32'(vrf[0][i]), 32'hA000 + 32'(i));

    // store 0x0200
    for (int i = 0; i < V; i++)
      vrf[0][i] = 16'h5500 + 16'(i);
    run(0, 1'b1, 16'h0200, 0, 16'h0, 0, dc, nr, nw, nd);
    chk("st_done_cyc", 0, 32'(dc), 32'd17);
    chk("st_nwr", 0, 32'(nw), 32'd16);
    chk("st_nrd", 0, 32'(nr), 32'd0);
    chk("st_ndone", 0, 32'(nd), 32'd1);
    for (int i = 0; i < V; i++)
      chk("st_mem", i, 32'(mem[0][16'h0200 + 16'(i)]),
          32'h5500 + 32'(i));

    // store 0x0400 with a stray Start in cycle 5
    run(0, 1'b1, 16'h0400, 5, 16'h0300, 0, dc, nr, nw, nd);
    chk("ig_done_cyc", 0, 32'(dc), 32'd17);
    chk("ig_ndone", 0, 32'(nd), 32'd1);
    chk("ig_nwr", 0, 32'(nw), 32'd16);
    chk("ig_nrd", 0, 32'(nr), 32'd0);
    for (int i = 0; i < V; i++) begin
      chk("ig_mem", i, 32'(mem[0][16'h0400 + 16'(i)]),
          32'h5500 + 32'(i));
      chk("ig_untouched", i,
          32'(mem[0][16'h0300 + 16'(i)]),
          32'((16'h0300 + 16'(i)) ^ 16'h3C3C));
    end

    // wrapping load from 0xFFF8
    run(0, 1'b0, 16'hFFF8, 0, 16'h0, 0, dc, nr, nw, nd);
    chk("wr_done_cyc", 0, 32'(dc), 32'd18);
    chk("wr_vrf0", 0, 32'(vrf[0][0]), 32'hB000);
    chk("wr_vrf7", 0, 32'(vrf[0][7]), 32'hB007);
    chk("wr_vrf8", 0, 32'(vrf[0][8]), 32'hB008);
    chk("wr_vrf15", 0, 32'(vrf[0][15]), 32'hB00F);

    // reset in cycle 6 of a load, then a clean load
    for (int i = 0; i < V; i++)
      vrf[0][i] = 16'h0;
    run(0, 1'b0, 16'h0100, 0, 16'h0, 6, dc, nr, nw, nd);
    chk("rs_ndone", 0, 32'(nd), 32'd0);
    chk("rs_nrd", 0, 32'(nr), 32'd6);
    chk("rs_vrf4", 0, 32'(vrf[0][4]), 32'hA004);
    chk("rs_vrf5", 0, 32'(vrf[0][5]), 32'h0);
    run(0, 1'b0, 16'h0100, 0, 16'h0, 0, dc, nr, nw, nd);
    chk("rs2_done_cyc", 0, 32'(dc), 32'd18);
    chk("rs2_ndone", 0, 32'(nd), 32'd1);
    for (int i = 0; i < V; i++)
      chk("rs2_vrf", i, 32'(vrf[0][i]), 32'hA000 + 32'(i));

    // RD_LAT=3 load
    run(1, 1'b0, 16'h0100, 0, 16'h0, 0, dc, nr, nw, nd);
    chk("l3_done_cyc", 1, 32'(dc), 32'd20);
    chk("l3_nrd", 1, 32'(nr), 32'd16);
    chk("l3_ndone", 1, 32'(nd), 32'd1);
    for (int i = 0; i < V; i++)
      chk("l3_vrf", i, 32'(vrf[1][i]), 32'hC000 + 32'(i));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/vldst_unit.md
# vldst_unit

Vector load/store sequencer for the CVP14 core. On a single start pulse it streams one vector register (VLEN 16-bit elements) between the vector register file (VRF) and the DRAM port, generating consecutive addresses and driving Addr/RD/WR/DataOut. It sits between the CVP14 control FSM (upstream) and the DRAM model (downstream), and owns the memory bus only while busy.

## Interface
- VLEN, 16, elements per vector; power of two, ≥2
- RD_LAT, 1, DRAM read latency in Clk1 cycles from RD/Addr to valid DataIn; ≥1
- Clk1  in  1  sole clock, rising-edge
- Reset  in  1  synchronous, active-high
- Start  in  1  one-cycle request; sampled only in IDLE
- Op  in  1  0 = load (DRAM→VRF), 1 = store (VRF→DRAM); sampled with Start
- BaseAddr  in  16  element-0 address; sampled with Start
- Busy  out  1  high from the cycle after an accepted Start until Done
- Done  out  1  one-cycle completion pulse
- VrfIdx  out  log2(VLEN)  element index for VRF read/write
- VrfRdData  in  16  VRF element at VrfIdx (combinational read)
- VrfWrEn  out  1  VRF write strobe
- VrfWrData  out  16  data written to element VrfIdx
- Addr  out  16  DRAM address
- RD  out  1  DRAM read strobe
- WR  out  1  DRAM write strobe
- DataOut  out  16  DRAM write data
- DataIn  in  16  DRAM read data

## Operation
- States: IDLE, LOAD, LDRAIN, STORE, DONE.
- IDLE: Start=1 latches Op/BaseAddr, clears the element counter i, and moves to LOAD (Op=0) or STORE (Op=1). Start in any other state is ignored (no queueing).
- LOAD: one read issued per cycle: Addr=BaseAddr+i, RD=1, i++. After i=VLEN-1 is issued, go to LDRAIN.
- Each issued index travels down an RD_LAT-deep valid/index pipe. On pipe output: VrfWrEn=1, VrfIdx=that index, VrfWrData=DataIn.
- LDRAIN: RD=0; waits until the pipe is empty (last write done), then DONE.
- STORE: VrfIdx=i, DataOut=VrfRdData (combinational pass-through), Addr=BaseAddr+i, WR=1, i++. After i=VLEN-1, go to DONE.
- DONE: Done=1 for one cycle, Busy=0, then IDLE.
- Address arithmetic: 16-bit modulo; BaseAddr+i wraps 0xFFFF→0x0000 with no error.
- RD and WR are never high in the same cycle.
- Reset, including mid-transfer: state IDLE, pipe flushed, counter cleared; no Done and no further VRF writes. A partially written vector is left as is.

## Timing
- Reset values: Busy=0, Done=0, VrfWrEn=0, VrfIdx=0, VrfWrData=0, RD=0, WR=0, DataOut=0, Addr=0x0000.
- Addr idles at 0x0000 because 0xFFFF is the bench halt sentinel. Addr is 0x0000 whenever RD=WR=0.
- Let cycle 0 be the cycle Start is sampled high in IDLE.
- Load:
  - RD high in cycles 1..VLEN.
  - VRF writes in cycles 1+RD_LAT..VLEN+RD_LAT.
  - Done in cycle VLEN+RD_LAT+1.
  - Busy in cycles 1..VLEN+RD_LAT.
- Store:
  - WR high in cycles 1..VLEN.
  - Done in cycle VLEN+1.
  - Busy in cycles 1..VLEN.
- Start during the DONE cycle is ignored. The earliest next Start is sampled the cycle after Done.
- All outputs except DataOut (combinational from VrfRdData during STORE) are registered.

## Structure
- Shared package cvp14_pkg holds:
  - VLEN and the data/address widths
  - OP_LOAD/OP_STORE encoding
  - the vldst state enum
- Sub-module vldst_rdpipe: parameterized RD_LAT-deep shift register of {valid, index}, with synchronous clear on Reset.

## Test plan
- Load, BaseAddr=0x0100, mem[0x0100+i]=0xA000+i, RD_LAT=1 -> VRF[i]=0xA000+i for i=0..15; RD in cycles 1..16; Done in cycle 18; Addr=0x0000 before and after.
- Store, BaseAddr=0x0200, VRF[i]=0x5500+i -> mem[0x0200+i]=0x5500+i; WR in cycles 1..16; Done in cycle 17; RD never asserted.
- Wrap, load with BaseAddr=0xFFF8 -> addresses 0xFFF8..0xFFFF then 0x0000..0x0007; VRF[8]=mem[0x0000].
- Start pulsed again in cycle 5 of a store with a different BaseAddr -> ignored; exactly 16 writes to the original range; single Done.
- Reset asserted in cycle 6 of a load -> next cycle: Busy=0, RD=0, VrfWrEn=0; no Done. A following Start executes a full load normally.
- RD_LAT=3 load -> VRF writes in cycles 4..19; Done in cycle 20; correct data per index.
